// File: rtl/hamming_enc_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_enc_stream_if
// Description : Valid/ready bundle for the Hamming(15,11) streaming encoder.
//               It carries both the 11-bit data input stream and the 15-bit
//               codeword output stream.
//               slave  - encoder side: consumes in_*, produces out_*
//               master - environment side: produces in_*, consumes out_*
// Ports       : in_valid, in_ready, in_data[10:0],
//               out_valid, out_ready, out_code[14:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_enc_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_code
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_code
  );
endinterface
`default_nettype wire

// File: rtl/hamming_enc_stream.sv
`default_nettype none
// ============================================================================
// Module      : hamming_enc_stream
// Description : Streaming Hamming(15,11) even-parity encoder with an output
//               codeword FIFO. Data words accepted on the input handshake are
//               encoded and stored; the FIFO head is presented on the output
//               handshake.
// Ports       : clk, rst (sync, active-high)
//               bus        - hamming_enc_stream_if.slave (in_*/out_* streams)
//               inj_en, inj_pos - error injection (only with HAMMING_ERR_INJ_EN)
//               fifo_level - occupied FIFO entries
//               word_cnt   - codewords delivered (wraps)
// Config      : define HAMMING_ERR_INJ_EN to add single-bit error injection
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_enc_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  hamming_enc_stream_if.slave                bus,
`ifdef HAMMING_ERR_INJ_EN
  input  wire logic                          inj_en,
  input  wire logic [3:0]                    inj_pos,
`endif
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [CNT_W-1:0]                   word_cnt
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             LW       = AW + 1;
  localparam logic [LW-1:0]  FULL_LVL = LW'(FIFO_DEPTH);

  logic [14:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q,  level_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [14:0]       last_q,   last_d;

  logic [14:0]       enc_w;
  logic [14:0]       code_w;
  logic              push_w;
  logic              pop_w;
  logic              ready_w;
  logic              valid_w;

  // Codeword layout: code[k] is Hamming position k+1. Data fills the
  // non-power-of-two positions in ascending order; each parity bit covers
  // the positions whose index has its bit set.
  always_comb begin
    enc_w     = '0;
    enc_w[2]  = bus.in_data[0];
    enc_w[4]  = bus.in_data[1];
    enc_w[5]  = bus.in_data[2];
    enc_w[6]  = bus.in_data[3];
    enc_w[8]  = bus.in_data[4];
    enc_w[9]  = bus.in_data[5];
    enc_w[10] = bus.in_data[6];
    enc_w[11] = bus.in_data[7];
    enc_w[12] = bus.in_data[8];
    enc_w[13] = bus.in_data[9];
    enc_w[14] = bus.in_data[10];
    // position 1: 3,5,7,9,11,13,15
    enc_w[0]  = enc_w[2] ^ enc_w[4] ^ enc_w[6] ^ enc_w[8] ^
                enc_w[10] ^ enc_w[12] ^ enc_w[14];
    // position 2: 3,6,7,10,11,14,15
    enc_w[1]  = enc_w[2] ^ enc_w[5] ^ enc_w[6] ^ enc_w[9] ^
                enc_w[10] ^ enc_w[13] ^ enc_w[14];
    // position 4: 5,6,7,12,13,14,15
    enc_w[3]  = enc_w[4] ^ enc_w[5] ^ enc_w[6] ^ enc_w[11] ^
                enc_w[12] ^ enc_w[13] ^ enc_w[14];
    // position 8: 9..15
    enc_w[7]  = enc_w[8] ^ enc_w[9] ^ enc_w[10] ^ enc_w[11] ^
                enc_w[12] ^ enc_w[13] ^ enc_w[14];
  end

`ifdef HAMMING_ERR_INJ_EN
  // One-hot at bit inj_pos, then dropped by one so position p lands on
  // code[p-1]; inj_pos=0 shifts the only set bit out and disables injection.
  logic [15:0] inj_sh_w;
  logic [14:0] inj_mask_w;
  always_comb begin
    inj_sh_w   = 16'd1 << inj_pos;
    inj_mask_w = inj_en ? inj_sh_w[15:1] : 15'd0;
    code_w     = enc_w ^ inj_mask_w;
  end
`else
  assign code_w = enc_w;
`endif

  // Flow control depends on registered occupancy only, so a pop on a full
  // FIFO does not open the input in the same cycle.
  assign ready_w = (level_q != FULL_LVL);
  assign valid_w = (level_q != '0);
  assign push_w  = bus.in_valid && ready_w;
  assign pop_w   = valid_w && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + CNT_W'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_w, pop_w})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: occupancy decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_w && !rst) begin
      mem_q[wr_ptr_q] <= code_w;
    end
  end

  // When empty, the last popped codeword is held (zero after reset).
  assign bus.in_ready  = ready_w;
  assign bus.out_valid = valid_w;
  assign bus.out_code  = valid_w ? mem_q[rd_ptr_q] : last_q;
  assign fifo_level    = level_q;
  assign word_cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_enc_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_enc_stream
// Description : Self-checking bench for hamming_enc_stream. A queue-based
//               reference model tracks the FIFO contents and is compared
//               against the DUT every falling edge; directed tests add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_enc_stream;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]    fifo_level;
  logic [CW-1:0] word_cnt;
  logic inj_en = 1'b0;
  logic [3:0] inj_pos = 4'd0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  hamming_enc_stream_if hif ();

  hamming_enc_stream #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (hif),
`ifdef HAMMING_ERR_INJ_EN
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
`endif
    .fifo_level (fifo_level),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder built directly from the position rules.
  function automatic logic [14:0] model_enc(input logic [10:0] d, input logic en,
                                            input logic [3:0] pos);
    logic [14:0] c;
    logic        par;
    int          k;
    int          ip;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if (((p >> j) & 1) == 1 && p != (1 << j)) par = par ^ c[p-1];
      end
      c[(1 << j) - 1] = par;
    end
    ip = int'(pos);
    if (en && ip != 0) c[ip-1] = ~c[ip-1];
    return c;
  endfunction

  // Reference state
  logic [14:0] expq[$];
  logic [14:0] mlast = '0;
  int          mcnt  = 0;

  always @(negedge clk) begin
    bit m_push, m_pop;
    if (chk_en) begin
      chk("out_valid",  {31'd0, hif.out_valid}, {31'd0, expq.size() != 0});
      chk("in_ready",   {31'd0, hif.in_ready},  {31'd0, expq.size() != DEPTH});
      chk("fifo_level", {29'd0, fifo_level},    32'(expq.size()));
      chk("word_cnt",   {28'd0, word_cnt},      32'(mcnt % (1 << CW)));
      chk("out_code",   {17'd0, hif.out_code},  {17'd0, (expq.size() != 0) ? expq[0] : mlast});
    end
    if (rst) begin
      expq.delete();
      mlast = '0;
      mcnt  = 0;
    end else begin
      m_pop  = (expq.size() != 0) && hif.out_ready;
      m_push = hif.in_valid && (expq.size() != DEPTH);
      if (m_pop) begin
        mlast = expq.pop_front();
        mcnt++;
      end
      if (m_push) expq.push_back(model_enc(hif.in_data, inj_en, inj_pos));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] d);
    int n;
    hif.in_valid = 1'b1;
    hif.in_data  = d;
    n = 0;
    while (!hif.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
    end
    step();
    hif.in_valid = 1'b0;
  endtask

  logic [10:0] fill_tbl [5] = '{11'h123, 11'h456, 11'h089, 11'h7AB, 11'h3CD};

  initial begin
    hif.in_valid  = 1'b0;
    hif.in_data   = '0;
    hif.out_ready = 1'b0;

    // Model pins
    chk("model_001", {17'd0, model_enc(11'h001, 1'b0, 4'd0)}, 32'h0007);
    chk("model_000", {17'd0, model_enc(11'h000, 1'b0, 4'd0)}, 32'h0000);
    chk("model_7ff", {17'd0, model_enc(11'h7FF, 1'b0, 4'd0)}, 32'h7FFF);
    chk("model_inj", {17'd0, model_enc(11'h001, 1'b1, 4'd5)}, 32'h0017);

    // 1: reset held 2 cycles
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", {31'd0, hif.out_valid}, 32'd0);
    chk("rst_ready", {31'd0, hif.in_ready},  32'd1);
    chk("rst_level", {29'd0, fifo_level},    32'd0);
    chk("rst_cnt",   {28'd0, word_cnt},      32'd0);
    chk("rst_code",  {17'd0, hif.out_code},  32'd0);
    rst = 1'b0;
    step();

    // 2: three words streamed straight through
    hif.out_ready = 1'b1;
    hif.in_valid  = 1'b1;
    hif.in_data   = 11'h001;
    step();
    chk("t2_code0", {17'd0, hif.out_code}, 32'h0007);
    hif.in_data = 11'h000;
    step();
    chk("t2_code1", {17'd0, hif.out_code}, 32'h0000);
    hif.in_data = 11'h7FF;
    step();
    chk("t2_code2", {17'd0, hif.out_code}, 32'h7FFF);
    hif.in_valid = 1'b0;
    step();
    chk("t2_cnt",  {28'd0, word_cnt},     32'd3);
    chk("t2_hold", {17'd0, hif.out_code}, 32'h7FFF);

    // 3: stall output, offer five words, only four fit
    hif.out_ready = 1'b0;
    hif.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hif.in_data = fill_tbl[i];
      step();
    end
    hif.in_valid = 1'b0;
    chk("t3_level", {29'd0, fifo_level},   32'd4);
    chk("t3_ready", {31'd0, hif.in_ready}, 32'd0);
    hif.out_ready = 1'b1;
    repeat (4) step();
    chk("t3_drain", {31'd0, hif.in_ready}, 32'd1);
    chk("t3_last",  {17'd0, hif.out_code}, {17'd0, model_enc(11'h7AB, 1'b0, 4'd0)});

    // 4: full FIFO with push and pop requested together
    hif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(11'(i * 11'h111 + 11'h0F0));
    hif.in_valid  = 1'b1;
    hif.in_data   = 11'h2AA;
    hif.out_ready = 1'b1;
    chk("t4_full_ready", {31'd0, hif.in_ready}, 32'd0);
    step();
    chk("t4_pop_only", {29'd0, fifo_level},   32'd3);
    chk("t4_reopen",   {31'd0, hif.in_ready}, 32'd1);
    step();
    hif.in_valid = 1'b0;
    chk("t4_pushpop", {29'd0, fifo_level}, 32'd3);
    repeat (4) step();

`ifdef HAMMING_ERR_INJ_EN
    // 6: single-bit error at position 5
    inj_en       = 1'b1;
    inj_pos      = 4'd5;
    hif.in_valid = 1'b1;
    hif.in_data  = 11'h001;
    step();
    chk("t6_inj", {17'd0, hif.out_code}, 32'h0017);
    hif.in_valid = 1'b0;
    inj_en       = 1'b0;
    inj_pos      = 4'd0;
    step();
`endif

    // 5: reset with three words buffered
    hif.out_ready = 1'b0;
    send(11'h111);
    send(11'h222);
    send(11'h333);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_level", {29'd0, fifo_level},    32'd0);
    chk("t5_valid", {31'd0, hif.out_valid}, 32'd0);
    chk("t5_cnt",   {28'd0, word_cnt},      32'd0);
    chk("t5_code",  {17'd0, hif.out_code},  32'd0);
    hif.out_ready = 1'b1;
    send(11'h555);
    send(11'h0AA);
    step();
    chk("t5_post", {17'd0, hif.out_code}, {17'd0, model_enc(11'h0AA, 1'b0, 4'd0)});

    // Counter wrap: 2 + 20 deliveries on a 4-bit counter
    hif.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hif.in_data = 11'(i * 97 + 5);
      step();
    end
    hif.in_valid = 1'b0;
    repeat (3) step();
    chk("wrap_cnt", {28'd0, word_cnt}, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
